regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 2R/1W register file between the in-order writeback stage (WB) and a multi-cycle unit (MC: divider/load unit), buffering MC results in a small FIFO. It also keeps a per-register pending-write scoreboard so decode can stall on registers whose MC result is still outstanding. It sits between the WB/MC producers and the register file's `wrData`/`wrNum`/`wrEnable` inputs.

## Interface
- `DEPTH`, default 2: MC result FIFO entries, a power of two and at least 2.
- `STARVE_LIMIT`, default 4: consecutive cycles the MC FIFO head may lose to WB before WB is stalled.
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `wbValid` in, 1: WB write request.
- `wbNum` in, `RegNumPath: WB destination register.
- `wbData` in, `DataPath: WB data.
- `wbStall` out, 1: WB request not consumed this cycle; the pipeline holds `wb*` stable.
- `mcValid` in, 1: MC result valid.
- `mcReady` out, 1: FIFO can accept.
- `mcNum` in, `RegNumPath: MC destination register.
- `mcData` in, `DataPath: MC data.
- `mcIssueValid` in, 1: MC op issued.
- `mcIssueNum` in, `RegNumPath: its destination register; marks the scoreboard.
- `queryNumA`, `queryNumB` in, `RegNumPath: decode source registers.
- `busyA`, `busyB` out, 1: queried register has a pending MC write.
- `wrEnable` out, 1: to register file.
- `wrNum` out, `RegNumPath: to register file.
- `wrData` out, `DataPath: to register file.
- `pendingCount` out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Reset (`rst_n`=0, immediate): FIFO empty, scoreboard all clear, starve counter 0.
- Reset output values: `wrEnable`=0, `wrNum`=0, `wrData`=0, `pendingCount`=0, `mcReady`=0, `wbStall`=0.
- FIFO push when `mcValid && mcReady`. `mcReady` = !full && `rst_n`. An MC result to r0 is accepted and discarded: no push, no scoreboard clear.
- WB request is effective when `wbValid && wbNum!=0`. A WB write to r0 is consumed silently.
- Grant each cycle:
  - Stall case: starve counter == `STARVE_LIMIT` and FIFO non-empty → grant MC head, `wbStall`=1 if WB request effective.
  - Otherwise, WB effective → grant WB.
  - Otherwise, FIFO non-empty → grant MC head (pop).
  - Otherwise, no grant.
- Starve counter:
  - Increments when the FIFO is non-empty and WB wins.
  - Resets to 0 on any MC grant or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- Granted request is registered into `wrEnable`/`wrNum`/`wrData` at the next edge. With no grant, `wrEnable`=0 and `wrNum`/`wrData` hold their values.
- Scoreboard, one bit per register, `REG_FILE_SIZE` bits:
  - Set on `mcIssueValid && mcIssueNum!=0`.
  - Cleared on the edge an MC entry is granted.
  - Simultaneous set and clear of the same bit: set wins.
- WB writes never touch the scoreboard. `busyA`/`busyB` are combinational reads of the scoreboard; r0 always reads 0.
- Push and pop in the same cycle when full is not allowed: `mcReady` is 0 when full, regardless of pop.

## Timing
- WB request at cycle t, not stalled → `wrEnable`=1 with its data in t+1 → register file updated at the end of t+1.
- MC accepted at t with no WB competition → granted at t+1 → `wrEnable` in t+2. Minimum MC latency is 2.
- `wbStall` and `mcReady` are combinational from registered state only, with no input-to-output paths. `busyA`/`busyB` are combinational from `queryNum*` and the scoreboard.
- Worst-case MC wait while non-empty: `STARVE_LIMIT`+1 cycles.

## Structure
- `DataPath`, `RegNumPath` and `REG_FILE_SIZE` come from the shared types file.
- Add `REG_NUM_ZERO` to the shared types file.
- One sub-module, `regfile_wr_fifo`: parameterised synchronous FIFO, async active-low reset, with `full`, `empty` and `count`.
- The arbiter, starve counter and scoreboard live in the top module.

## Test plan
- Reset mid-operation: FIFO holding 2 entries, scoreboard bit r3 set, assert `rst_n`=0 → all outputs 0 immediately, `busy` for r3 = 0, `mcReady`=1 after release.
- WB only: `wbValid`, `wbNum`=5, `wbData`=0x1234 at t → `wrEnable`=1, `wrNum`=5, `wrData`=0x1234 at t+1. Same stimulus with `wbNum`=0 → `wrEnable` stays 0.
- MC with scoreboard:
  - `mcIssueNum`=2 at t0 → `busyA`=1 for `queryNumA`=2 from t0+1.
  - `mcNum`=2, `mcData`=0xBEEF accepted at t1 → write at t1+2; `busyA` drops after the grant edge.
- Starvation: FIFO holds one entry, `wbValid` continuous, `STARVE_LIMIT`=4 → `wbStall`=1 on the 5th cycle, MC written, WB written the following cycle with held data.
- Full FIFO: push 2 entries while WB blocks → `mcReady`=0, `pendingCount`=2. A third `mcValid` is not accepted until a pop.
- Issue to r4 in the same cycle as the MC grant of an older r4 entry → r4 remains busy.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file types and helpers for the write-port arbiter and its MC result FIFO.
package regfile_write_arbiter_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_NUM_WIDTH = 5;
    localparam int REG_FILE_SIZE = 1 << REG_NUM_WIDTH;

    typedef logic [DATA_WIDTH-1:0]    DataPath;
    typedef logic [REG_NUM_WIDTH-1:0] RegNumPath;

    localparam RegNumPath REG_NUM_ZERO = '0;

    typedef struct packed {
        RegNumPath num;
        DataPath   data;
    } McEntry;

    localparam int MC_ENTRY_WIDTH = $bits(McEntry);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_MC   = 2'd2
    } GrantSel;

    function automatic logic [REG_FILE_SIZE-1:0] regOneHot(input RegNumPath num);
        logic [REG_FILE_SIZE-1:0] vec;
        vec      = '0;
        vec[num] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small synchronous FIFO holding multi-cycle unit results until they win the register-file write port.
module regfile_wr_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pushValid_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     popValid_i,
    output logic [WIDTH-1:0]         headData_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty_o    = (wrPtr_q == rdPtr_q);
    assign count_o    = wrPtr_q - rdPtr_q;
    assign headData_o = mem_q[rdPtr_q[AW-1:0]];

    assign doPush  = pushValid_i && !full_o;
    assign doPop   = popValid_i && !empty_o;
    assign wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    assign rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between in-order writeback and a buffered multi-cycle unit,
// with a starvation guard and a pending-write scoreboard for decode.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wbValid,
    input  RegNumPath                wbNum,
    input  DataPath                  wbData,
    output logic                     wbStall,
    input  logic                     mcValid,
    output logic                     mcReady,
    input  RegNumPath                mcNum,
    input  DataPath                  mcData,
    input  logic                     mcIssueValid,
    input  RegNumPath                mcIssueNum,
    input  RegNumPath                queryNumA,
    input  RegNumPath                queryNumB,
    output logic                     busyA,
    output logic                     busyB,
    output logic                     wrEnable,
    output RegNumPath                wrNum,
    output DataPath                  wrData,
    output logic [$clog2(DEPTH):0]   pendingCount
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [$clog2(DEPTH):0]   fifoCount;
    McEntry                   fifoHead;
    McEntry                   pushEntry;
    logic                     fifoPush;
    logic                     fifoPop;

    logic                     wbEffective;
    logic                     stallCase;
    GrantSel                  grantSel;

    logic [STARVE_W-1:0]      starveCnt_q, starveCnt_d;
    logic [REG_FILE_SIZE-1:0] scoreboard_q, scoreboard_d;
    logic [REG_FILE_SIZE-1:0] sbSet;
    logic [REG_FILE_SIZE-1:0] sbClr;

    logic                     wrEnable_q, wrEnable_d;
    RegNumPath                wrNum_q, wrNum_d;
    DataPath                  wrData_q, wrData_d;

    // Results destined for r0 are acknowledged but never buffered.
    assign pushEntry = '{num: mcNum, data: mcData};
    assign mcReady   = !fifoFull && rst_n;
    assign fifoPush  = mcValid && mcReady && (mcNum != REG_NUM_ZERO);
    assign fifoPop   = (grantSel == GRANT_MC);

    regfile_wr_fifo #(
        .WIDTH (MC_ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .pushValid_i (fifoPush),
        .pushData_i  (pushEntry),
        .popValid_i  (fifoPop),
        .headData_o  (fifoHead),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .count_o     (fifoCount)
    );

    assign pendingCount = fifoCount;
    assign wbEffective  = wbValid && (wbNum != REG_NUM_ZERO);

    // wbStall depends only on registered state; the counter can only sit at the limit
    // while WB has been winning, so the held WB request is what gets stalled.
    assign stallCase = (starveCnt_q == STARVE_MAX) && !fifoEmpty;
    assign wbStall   = stallCase;

    always_comb begin
        grantSel = GRANT_NONE;
        if (stallCase) begin
            grantSel = GRANT_MC;
        end else if (wbEffective) begin
            grantSel = GRANT_WB;
        end else if (!fifoEmpty) begin
            grantSel = GRANT_MC;
        end
    end

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (fifoEmpty || grantSel == GRANT_MC) begin
            starveCnt_d = '0;
        end else if (grantSel == GRANT_WB && starveCnt_q != STARVE_MAX) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    // A new issue to a register wins over retiring an older result to the same register.
    always_comb begin
        sbSet = '0;
        sbClr = '0;
        if (mcIssueValid && mcIssueNum != REG_NUM_ZERO) begin
            sbSet = regOneHot(mcIssueNum);
        end
        if (grantSel == GRANT_MC) begin
            sbClr = regOneHot(fifoHead.num);
        end
        scoreboard_d = (scoreboard_q & ~sbClr) | sbSet;
    end

    assign busyA = (queryNumA != REG_NUM_ZERO) && scoreboard_q[queryNumA];
    assign busyB = (queryNumB != REG_NUM_ZERO) && scoreboard_q[queryNumB];

    always_comb begin
        wrEnable_d = 1'b0;
        wrNum_d    = wrNum_q;
        wrData_d   = wrData_q;
        case (grantSel)
            GRANT_WB: begin
                wrEnable_d = 1'b1;
                wrNum_d    = wbNum;
                wrData_d   = wbData;
            end
            GRANT_MC: begin
                wrEnable_d = 1'b1;
                wrNum_d    = fifoHead.num;
                wrData_d   = fifoHead.data;
            end
            default: begin
                wrEnable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt_q  <= '0;
            scoreboard_q <= '0;
            wrEnable_q   <= 1'b0;
            wrNum_q      <= '0;
            wrData_q     <= '0;
        end else begin
            starveCnt_q  <= starveCnt_d;
            scoreboard_q <= scoreboard_d;
            wrEnable_q   <= wrEnable_d;
            wrNum_q      <= wrNum_d;
            wrData_q     <= wrData_d;
        end
    end

    assign wrEnable = wrEnable_q;
    assign wrNum    = wrNum_q;
    assign wrData   = wrData_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter with hand-computed expected values.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       wbValid;
    RegNumPath  wbNum;
    DataPath    wbData;
    logic       wbStall;
    logic       mcValid;
    logic       mcReady;
    RegNumPath  mcNum;
    DataPath    mcData;
    logic       mcIssueValid;
    RegNumPath  mcIssueNum;
    RegNumPath  queryNumA;
    RegNumPath  queryNumB;
    logic       busyA;
    logic       busyB;
    logic       wrEnable;
    RegNumPath  wrNum;
    DataPath    wrData;
    logic [1:0] pendingCount;

    int checkCount;
    int failCount;

    regfile_write_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wbValid      (wbValid),
        .wbNum        (wbNum),
        .wbData       (wbData),
        .wbStall      (wbStall),
        .mcValid      (mcValid),
        .mcReady      (mcReady),
        .mcNum        (mcNum),
        .mcData       (mcData),
        .mcIssueValid (mcIssueValid),
        .mcIssueNum   (mcIssueNum),
        .queryNumA    (queryNumA),
        .queryNumB    (queryNumB),
        .busyA        (busyA),
        .busyB        (busyB),
        .wrEnable     (wrEnable),
        .wrNum        (wrNum),
        .wrData       (wrData),
        .pendingCount (pendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wbV, input RegNumPath wbN, input DataPath wbD,
                                 input logic mcV, input RegNumPath mcN, input DataPath mcD,
                                 input logic issV, input RegNumPath issN);
        wbValid      = wbV;
        wbNum        = wbN;
        wbData       = wbD;
        mcValid      = mcV;
        mcNum        = mcN;
        mcData       = mcD;
        mcIssueValid = issV;
        mcIssueNum   = issN;
    endtask

    // Registered outputs are sampled 2 time units after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        queryNumA  = '0;
        queryNumB  = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #3;
        checkOutput("rst_wrEnable", 32'(wrEnable), 32'd0);
        checkOutput("rst_wrNum", 32'(wrNum), 32'd0);
        checkOutput("rst_wrData", wrData, 32'd0);
        checkOutput("rst_pendingCount", 32'(pendingCount), 32'd0);
        checkOutput("rst_mcReady", 32'(mcReady), 32'd0);
        checkOutput("rst_wbStall", 32'(wbStall), 32'd0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_mcReady", 32'(mcReady), 32'd1);

        $display("[TB] WB-only writes");
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        nextCycle();
        checkOutput("wb_wrEnable", 32'(wrEnable), 32'd1);
        checkOutput("wb_wrNum", 32'(wrNum), 32'd5);
        checkOutput("wb_wrData", wrData, 32'h1234);
        applyStimulus(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        nextCycle();
        checkOutput("wb_r0_wrEnable", 32'(wrEnable), 32'd0);
        checkOutput("wb_r0_wrNum_hold", 32'(wrNum), 32'd5);
        checkOutput("wb_r0_wrData_hold", wrData, 32'h1234);

        $display("[TB] MC result with scoreboard");
        queryNumA = 5'd2;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
        #1;
        checkOutput("sb_r2_before_edge", 32'(busyA), 32'd0);
        nextCycle();
        checkOutput("sb_r2_set", 32'(busyA), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0);
        #1;
        checkOutput("mc_ready_accept", 32'(mcReady), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("mc_pending_1", 32'(pendingCount), 32'd1);
        checkOutput("mc_wrEnable_t1p1", 32'(wrEnable), 32'd0);
        checkOutput("mc_busy_before_grant", 32'(busyA), 32'd1);
        nextCycle();
        checkOutput("mc_wrEnable_t1p2", 32'(wrEnable), 32'd1);
        checkOutput("mc_wrNum", 32'(wrNum), 32'd2);
        checkOutput("mc_wrData", wrData, 32'hBEEF);
        checkOutput("mc_busy_cleared", 32'(busyA), 32'd0);
        checkOutput("mc_pending_0", 32'(pendingCount), 32'd0);
        nextCycle();
        checkOutput("mc_wrEnable_idle", 32'(wrEnable), 32'd0);

        $display("[TB] Starvation guard");
        queryNumB = 5'd7;
        applyStimulus(1'b1, 5'd9, 32'h2000, 1'b1, 5'd7, 32'hCAFE, 1'b1, 5'd7);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'h2000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("starve_nostall_%0d", i), 32'(wbStall), 32'd0);
            checkOutput($sformatf("starve_wbNum_%0d", i), 32'(wrNum), 32'd9);
            checkOutput($sformatf("starve_wbData_%0d", i), wrData, 32'h2000 + 32'(i - 1));
            wbData = 32'h2000 + 32'(i);
            nextCycle();
        end
        checkOutput("starve_stall", 32'(wbStall), 32'd1);
        checkOutput("starve_pending", 32'(pendingCount), 32'd1);
        checkOutput("starve_busy_r7", 32'(busyB), 32'd1);
        checkOutput("starve_wbData_4", wrData, 32'h2004);
        nextCycle();
        checkOutput("starve_mc_wrEnable", 32'(wrEnable), 32'd1);
        checkOutput("starve_mc_wrNum", 32'(wrNum), 32'd7);
        checkOutput("starve_mc_wrData", wrData, 32'hCAFE);
        checkOutput("starve_busy_r7_clear", 32'(busyB), 32'd0);
        checkOutput("starve_stall_release", 32'(wbStall), 32'd0);
        checkOutput("starve_pending_0", 32'(pendingCount), 32'd0);
        nextCycle();
        checkOutput("starve_wb_after_wrNum", 32'(wrNum), 32'd9);
        checkOutput("starve_wb_after_wrData", wrData, 32'h2004);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        nextCycle();

        $display("[TB] Full FIFO");
        applyStimulus(1'b1, 5'd10, 32'h3000, 1'b1, 5'd11, 32'hA1, 1'b0, 5'd0);
        nextCycle();
        checkOutput("full_pending_1", 32'(pendingCount), 32'd1);
        checkOutput("full_ready_1", 32'(mcReady), 32'd1);
        applyStimulus(1'b1, 5'd10, 32'h3000, 1'b1, 5'd12, 32'hA2, 1'b0, 5'd0);
        nextCycle();
        checkOutput("full_pending_2", 32'(pendingCount), 32'd2);
        checkOutput("full_ready_0", 32'(mcReady), 32'd0);
        checkOutput("full_wb_wrNum", 32'(wrNum), 32'd10);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hA3, 1'b0, 5'd0);
        nextCycle();
        checkOutput("full_third_rejected", 32'(pendingCount), 32'd1);
        checkOutput("full_pop1_wrNum", 32'(wrNum), 32'd11);
        checkOutput("full_pop1_wrData", wrData, 32'hA1);
        checkOutput("full_ready_after_pop", 32'(mcReady), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("full_push_pop_pending", 32'(pendingCount), 32'd1);
        checkOutput("full_pop2_wrNum", 32'(wrNum), 32'd12);
        checkOutput("full_pop2_wrData", wrData, 32'hA2);
        nextCycle();
        checkOutput("full_pop3_wrNum", 32'(wrNum), 32'd13);
        checkOutput("full_pop3_wrData", wrData, 32'hA3);
        checkOutput("full_drained", 32'(pendingCount), 32'd0);

        $display("[TB] r0 handling and issue/grant collision");
        queryNumA = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77, 1'b1, 5'd0);
        nextCycle();
        checkOutput("mc_r0_discard", 32'(pendingCount), 32'd0);
        checkOutput("busy_r0", 32'(busyA), 32'd0);
        queryNumA = 5'd4;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("collide_wrNum", 32'(wrNum), 32'd4);
        checkOutput("collide_wrData", wrData, 32'h44);
        checkOutput("collide_busy_r4", 32'(busyA), 32'd1);

        $display("[TB] Reset mid-operation");
        queryNumA = 5'd3;
        applyStimulus(1'b1, 5'd8, 32'h4000, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
        nextCycle();
        applyStimulus(1'b1, 5'd8, 32'h4000, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        nextCycle();
        checkOutput("midrst_pending_2", 32'(pendingCount), 32'd2);
        checkOutput("midrst_busy_r3", 32'(busyA), 32'd1);
        checkOutput("midrst_wrEnable", 32'(wrEnable), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wrEnable_0", 32'(wrEnable), 32'd0);
        checkOutput("midrst_wrNum_0", 32'(wrNum), 32'd0);
        checkOutput("midrst_wrData_0", wrData, 32'd0);
        checkOutput("midrst_pending_0", 32'(pendingCount), 32'd0);
        checkOutput("midrst_mcReady_0", 32'(mcReady), 32'd0);
        checkOutput("midrst_wbStall_0", 32'(wbStall), 32'd0);
        checkOutput("midrst_busy_r3_0", 32'(busyA), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_mcReady_release", 32'(mcReady), 32'd1);
        checkOutput("midrst_busy_release", 32'(busyA), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
